// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I load/store requests into single-word memory bus accesses.
// Optional macro RISKY_LSU_MISALIGN_TRAP_EN: misaligned H/W accesses complete with rsp_err instead of touching memory.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_rstrb,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wmask
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] load_ext;
  logic [4:0]      byte_off;
  logic [4:0]      half_off;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;

`ifdef RISKY_LSU_MISALIGN_TRAP_EN
  logic err_q, err_d;

  // funct3[1:0] alone selects the size, so 110/111 count as word accesses too.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a != 2'b00));
  endfunction
`endif

  // State and latched request fields.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
`ifdef RISKY_LSU_MISALIGN_TRAP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
`ifdef RISKY_LSU_MISALIGN_TRAP_EN
      err_q    <= err_d;
`endif
    end
  end

  // Lane extraction of the returned word; low address bits beyond the access size are ignored.
  assign byte_off  = {addr_q[1:0], 3'b000};
  assign half_off  = {addr_q[1], 4'b0000};
  assign load_byte = mem_rdata[byte_off +: 8];
  assign load_half = mem_rdata[half_off +: 16];

  always_comb begin
    // NOTE: default first so every path assigns load_ext and no latch is inferred.
    load_ext = mem_rdata;
    unique case (funct3_q[1:0])
      2'b00:   load_ext = {{(XLEN-8){~funct3_q[2] & load_byte[7]}}, load_byte};
      2'b01:   load_ext = {{(XLEN-16){~funct3_q[2] & load_half[15]}}, load_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
`ifdef RISKY_LSU_MISALIGN_TRAP_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          state_d  = req_we ? STORE : LOAD;
`ifdef RISKY_LSU_MISALIGN_TRAP_EN
          err_d    = is_misaligned(req_funct3, req_addr[1:0]);
          if (err_d) state_d = RESP;
`endif
        end
      end
      LOAD:  state_d = WAIT;
      WAIT: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      STORE: state_d = RESP;
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so reset clears them asynchronously.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    mem_addr  = ((state_q == LOAD) || (state_q == STORE)) ? addr_q : '0;
    mem_rstrb = (state_q == LOAD);
    mem_wmask = 4'b0000;
    mem_wdata = '0;
    if (state_q == STORE) begin
      unique case (funct3_q[1:0])
        2'b00: begin
          mem_wmask = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_wmask = 4'b0011 << {addr_q[1], 1'b0};
          mem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          mem_wmask = 4'b1111;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

`ifdef RISKY_LSU_MISALIGN_TRAP_EN
  assign rsp_err = (state_q == RESP) & err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Store direction is carried by the state encoding; we_q is kept for the latched request record.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory model, directed vectors and random traffic.
// Honours RISKY_LSU_MISALIGN_TRAP_EN when defined for both DUT and bench.
module tb_load_store_unit;

`ifdef RISKY_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  logic [7:0] bus_mem [256];
  logic [7:0] ref_mem [256];

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  always #5 clk = ~clk;

  // Bus-side word memory: read data appears the cycle after mem_rstrb, garbage otherwise.
  always @(posedge clk) begin
    int wa;
    wa = int'(mem_addr[7:0]) & 32'hFC;
    if (mem_rstrb)
      mem_rdata <= {bus_mem[wa+3], bus_mem[wa+2], bus_mem[wa+1], bus_mem[wa]};
    else
      mem_rdata <= $urandom;
    for (int l = 0; l < 4; l++)
      if (mem_wmask[l]) bus_mem[wa+l] <= mem_wdata[8*l +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request from IDLE; expectations come from the byte-array model ref_mem.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got_rd,
                         output logic [3:0] got_wm, output logic [31:0] got_wd);
    int size, base, exp_lat, n_rstrb, n_wm;
    bit uns, mis, trap, seen;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_wm;
    size   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    uns    = f3[2] && (size < 4);
    mis    = ((size == 2) && addr[0]) || ((size == 4) && (addr[1:0] != 2'b00));
    trap   = mis && TRAP;
    base   = int'(addr[7:0]) & ~(size - 1);
    exp_rd = 32'h0;
    exp_wm = 4'h0;
    exp_wd = 32'h0;
    if (trap) exp_lat = 1;
    else if (we) begin
      exp_lat = 2;
      for (int b = 0; b < size; b++) exp_wm[(base + b) % 4] = 1'b1;
      for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wdata[8*(j % size) +: 8];
      for (int b = 0; b < size; b++) ref_mem[base + b] = wdata[8*b +: 8];
    end else begin
      exp_lat = 3;
      for (int b = 0; b < size; b++) exp_rd = exp_rd | (32'(ref_mem[base + b]) << (8 * b));
      if (!uns && size == 1 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
      if (!uns && size == 2 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
    end
    got_rd = 32'hX; got_wm = 4'h0; got_wd = 32'h0;
    n_rstrb = 0; n_wm = 0; seen = 0;

    @(negedge clk);
    check("ready_idle", {31'b0, req_ready}, 32'd1);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = $urandom; req_funct3 = $urandom; req_addr = $urandom; req_wdata = $urandom;
    for (int lat = 1; lat <= 8; lat++) begin
      @(negedge clk);
      check("no_overlap", {31'b0, mem_rstrb && (mem_wmask != 4'h0)}, 32'd0);
      if (mem_rstrb) begin
        n_rstrb++;
        check("load_addr", mem_addr, addr);
      end
      if (mem_wmask != 4'h0) begin
        n_wm++;
        got_wm = mem_wmask; got_wd = mem_wdata;
        check("store_addr", mem_addr, addr);
        check("store_mask", {28'b0, mem_wmask}, {28'b0, exp_wm});
        check("store_data", mem_wdata, exp_wd);
      end
      if (rsp_valid) begin
        seen = 1;
        got_rd = rsp_rdata;
        check("latency", lat, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, trap});
        break;
      end
    end
    check("rsp_seen", {31'b0, seen}, 32'd1);
    check("rstrb_count", n_rstrb, (!we && !trap) ? 1 : 0);
    check("wmask_count", n_wm, (we && !trap) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, wd, exp_b2b;
    logic [3:0]  wm;
    int hs, nr, nv;

    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    bus_mem[8'h40] = 8'h01; bus_mem[8'h41] = 8'h7F; bus_mem[8'h42] = 8'hFF; bus_mem[8'h43] = 8'h80;
    for (int i = 8'h40; i < 8'h44; i++) ref_mem[i] = bus_mem[i];

    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'b0, rsp_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rstrb", {31'b0, mem_rstrb}, 32'd0);
    check("rst_wmask", {28'b0, mem_wmask}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    resetn = 1'b1;

    run_req(1'b0, 3'b000, 32'h43, 32'h0, rd, wm, wd); check("lb_43", rd, 32'hFFFF_FF80);
    run_req(1'b0, 3'b100, 32'h43, 32'h0, rd, wm, wd); check("lbu_43", rd, 32'h0000_0080);
    run_req(1'b0, 3'b001, 32'h42, 32'h0, rd, wm, wd); check("lh_42", rd, 32'hFFFF_80FF);
    run_req(1'b0, 3'b101, 32'h42, 32'h0, rd, wm, wd); check("lhu_42", rd, 32'h0000_80FF);
    run_req(1'b0, 3'b010, 32'h40, 32'h0, rd, wm, wd); check("lw_40", rd, 32'h80FF_7F01);
    run_req(1'b1, 3'b000, 32'h45, 32'h0000_00AB, rd, wm, wd);
    check("sb_45_mask", {28'b0, wm}, 32'h2);
    check("sb_45_data", wd, 32'hABAB_ABAB);
    check("sb_45_rdata", rd, 32'h0);
    run_req(1'b1, 3'b001, 32'h46, 32'h0000_1234, rd, wm, wd);
    check("sh_46_mask", {28'b0, wm}, 32'hC);
    check("sh_46_data", wd, 32'h1234_1234);
    run_req(1'b0, 3'b010, 32'h41, 32'h0, rd, wm, wd);
    check("lw_41", rd, TRAP ? 32'h0 : 32'h80FF_7F01);

    for (int n = 0; n < 60; n++)
      run_req(1'($urandom), 3'($urandom), 32'($urandom_range(0, 255)), $urandom, rd, wm, wd);

    // Reset during the STORE cycle of SW 0x44.
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h44; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("sw_mask_before_rst", {28'b0, mem_wmask}, 32'hF);
    resetn = 1'b0;
    #1;
    check("rst_mid_wmask", {28'b0, mem_wmask}, 32'd0);
    check("rst_mid_wdata", mem_wdata, 32'd0);
    check("rst_mid_addr", mem_addr, 32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_ready", {31'b0, req_ready}, 32'd1);
      check("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    run_req(1'b0, 3'b010, 32'h44, 32'h0, rd, wm, wd);

    // req_valid held high: a new load is accepted only every fourth cycle.
    exp_b2b = {ref_mem[8'h43], ref_mem[8'h42], ref_mem[8'h41], ref_mem[8'h40]};
    hs = 0; nr = 0; nv = 0;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (req_ready) hs++;
      if (mem_rstrb) nr++;
      check("b2b_no_overlap", {31'b0, mem_rstrb && (mem_wmask != 4'h0)}, 32'd0);
      if (rsp_valid) begin
        nv++;
        check("b2b_rdata", rsp_rdata, exp_b2b);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_handshakes", hs, 3);
    check("b2b_rstrb", nr, 3);
    check("b2b_rsp", nv, 3);
    @(negedge clk);
    check("b2b_idle", {31'b0, req_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
